// File: rtl/ca_pipe_pkg.sv
// Shared pipeline definitions: EX operand-mux select codes and default register address width.
// The 3:1 operand mux takes in0=RF, in1=WB, in2=MEM, so the select codes match those inputs.
package ca_pipe_pkg;

    localparam int RA_W_DEF = 5;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_WB  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;

endpackage

// File: rtl/fwd_sel_unit.sv
// Operand-forwarding selector for one EX source operand.
// The youngest producer (MEM) wins over WB. x0 is never forwarded.
module fwd_sel_unit
    import ca_pipe_pkg::*;
#(
    parameter int RA_W = RA_W_DEF
) (
    input  logic [RA_W-1:0] ex_rs,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_rw,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_rw,
    output fwd_sel_t        sel
);

    // Pick the nearest older writer of ex_rs; otherwise use the register file.
    always_comb begin
        sel = FWD_RF;
        if (mem_rw && (mem_rd != '0) && (mem_rd == ex_rs))
            sel = FWD_MEM;
        else if (wb_rw && (wb_rd != '0) && (wb_rd == ex_rs))
            sel = FWD_WB;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage core.
// It tracks dest/source info of the EX, MEM and WB stages in a private shadow pipeline.
module pipe_hazard_ctrl
    import ca_pipe_pkg::*;
#(
    parameter int RA_W         = RA_W_DEF,
    parameter int CNT_W        = 32,
    parameter bit WB_BYPASS_ID = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pipe_en,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             ex_br_taken,
    output fwd_sel_t         fwd_a_sel,
    output fwd_sel_t         fwd_b_sel,
    output logic             id_byp_a,
    output logic             id_byp_b,
    output logic             stall,
    output logic             flush_if_id,
    output logic             bubble_id_ex,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Shadow-stage layouts: EX keeps sources for forwarding and the load flag for load-use.
    typedef struct packed {
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic            rw;
        logic            mr;
    } ex_shadow_t;

    typedef struct packed {
        logic [RA_W-1:0] rd;
        logic            rw;
    } wr_shadow_t;

    ex_shadow_t       ex_q, ex_d;
    wr_shadow_t       mem_q, mem_d, wb_q, wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             lu;

    fwd_sel_unit #(.RA_W(RA_W)) u_fwd_a (
        .ex_rs (ex_q.rs1), .mem_rd(mem_q.rd), .mem_rw(mem_q.rw),
        .wb_rd (wb_q.rd),  .wb_rw (wb_q.rw),  .sel   (fwd_a_sel)
    );

    fwd_sel_unit #(.RA_W(RA_W)) u_fwd_b (
        .ex_rs (ex_q.rs2), .mem_rd(mem_q.rd), .mem_rw(mem_q.rw),
        .wb_rd (wb_q.rd),  .wb_rw (wb_q.rw),  .sel   (fwd_b_sel)
    );

    // Load-use detection, stall/flush generation and same-cycle WB->ID bypass selects.
    always_comb begin
        lu = ex_q.mr && (ex_q.rd != '0) &&
             ((id_use_rs1 && (id_rs1 == ex_q.rd)) || (id_use_rs2 && (id_rs2 == ex_q.rd)));
        // A memory wait freezes the pipe, so no control action may fire.
        flush_if_id  = pipe_en & ex_br_taken;
        bubble_id_ex = pipe_en & (ex_br_taken | lu);
        stall        = pipe_en & lu & ~ex_br_taken;
        id_byp_a     = WB_BYPASS_ID && wb_q.rw && (wb_q.rd != '0) && (wb_q.rd == id_rs1);
        id_byp_b     = WB_BYPASS_ID && wb_q.rw && (wb_q.rd != '0) && (wb_q.rd == id_rs2);
    end

    // Shadow pipeline advance and saturating event counters.
    always_comb begin
        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pipe_en) begin
            ex_d.rs1 = id_rs1;
            ex_d.rs2 = id_rs2;
            ex_d.rd  = bubble_id_ex ? '0   : id_rd;
            ex_d.rw  = bubble_id_ex ? 1'b0 : id_reg_write;
            ex_d.mr  = bubble_id_ex ? 1'b0 : id_mem_read;
            mem_d.rd = ex_q.rd;
            mem_d.rw = ex_q.rw;
            wb_d     = mem_q;
            if (stall && !(&stall_cnt_q))
                stall_cnt_d = stall_cnt_q + 1'b1;
            if (ex_br_taken && !(&flush_cnt_q))
                flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // State registers; reset clears all shadow state so every derived output drops at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: instruction-history model checked every cycle plus literal checks.
module tb_pipe_hazard_ctrl;

    localparam int RA_W  = 5;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pipe_en = 1'b1;
    logic [RA_W-1:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic             id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic             id_reg_write = 1'b0, id_mem_read = 1'b0, ex_br_taken = 1'b0;
    logic [1:0]       fwd_a_sel, fwd_b_sel;
    logic             id_byp_a, id_byp_b, stall, flush_if_id, bubble_id_ex;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_fail = 0;

    pipe_hazard_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W), .WB_BYPASS_ID(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .pipe_en(pipe_en),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_br_taken(ex_br_taken),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .id_byp_a(id_byp_a), .id_byp_b(id_byp_b),
        .stall(stall), .flush_if_id(flush_if_id), .bubble_id_ex(bubble_id_ex),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model: history of instructions that entered EX ----------------
    typedef struct packed {
        logic [RA_W-1:0] rs1, rs2, rd;
        logic            rw, mr;
    } rec_t;

    rec_t hist[$];  // [0]=EX, [1]=MEM, [2]=WB
    int   m_stall_cnt, m_flush_cnt;

    function automatic logic m_lu();
        rec_t e = hist[0];
        return e.mr && e.rd != 0 &&
               ((id_use_rs1 && id_rs1 == e.rd) || (id_use_rs2 && id_rs2 == e.rd));
    endfunction

    function automatic logic [1:0] m_fwd(input logic [RA_W-1:0] rs);
        for (int age = 1; age <= 2; age++)
            if (hist[age].rw && hist[age].rd != 0 && hist[age].rd == rs)
                return (age == 1) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist = '{rec_t'(0), rec_t'(0), rec_t'(0)};
            m_stall_cnt = 0;
            m_flush_cnt = 0;
        end else if (pipe_en) begin
            rec_t r;
            logic lu_now;
            lu_now = m_lu();
            r = '{rs1: id_rs1, rs2: id_rs2, rd: id_rd, rw: id_reg_write, mr: id_mem_read};
            if (ex_br_taken || lu_now) begin
                r.rd = 0; r.rw = 0; r.mr = 0;
            end
            if (lu_now && !ex_br_taken && m_stall_cnt < CMAX) m_stall_cnt++;
            if (ex_br_taken && m_flush_cnt < CMAX) m_flush_cnt++;
            hist.push_front(r);
            void'(hist.pop_back());
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (hist.size() == 3) begin
            logic lu_now;
            logic byp_a, byp_b;
            lu_now = m_lu();
            byp_a = hist[2].rw && hist[2].rd != 0 && hist[2].rd == id_rs1;
            byp_b = hist[2].rw && hist[2].rd != 0 && hist[2].rd == id_rs2;
            chk("m_fwd_a", fwd_a_sel, m_fwd(hist[0].rs1));
            chk("m_fwd_b", fwd_b_sel, m_fwd(hist[0].rs2));
            chk("m_byp_a", id_byp_a, byp_a);
            chk("m_byp_b", id_byp_b, byp_b);
            chk("m_stall", stall, pipe_en && lu_now && !ex_br_taken);
            chk("m_flush", flush_if_id, pipe_en && ex_br_taken);
            chk("m_bubble", bubble_id_ex, pipe_en && (lu_now || ex_br_taken));
            chk("m_stall_cnt", stall_cnt, m_stall_cnt);
            chk("m_flush_cnt", flush_cnt, m_flush_cnt);
        end
    end

    // ---------------- stimulus ----------------
    // Present one ID-stage instruction for a cycle; returns at the following negedge.
    task automatic issue(input logic [RA_W-1:0] rs1, rs2, input logic u1, u2,
                         input logic [RA_W-1:0] rd, input logic rw, mr, br, en);
        @(posedge clk);
        #1;
        id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr; ex_br_taken = br; pipe_en = en;
        @(negedge clk);
    endtask

    task automatic nop();
        issue(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic alu(input logic [RA_W-1:0] rd, rs1, rs2);
        issue(rs1, rs2, 1, 1, rd, 1, 0, 0, 1);
    endtask

    task automatic ld(input logic [RA_W-1:0] rd, rs1);
        issue(rs1, 0, 1, 0, rd, 1, 1, 0, 1);
    endtask

    initial begin
        #12 rst_n = 1'b1;
        nop();
        chk("rst_fwd_a", fwd_a_sel, 2'b00);
        chk("rst_stall_cnt", stall_cnt, 0);

        // Back-to-back dependency -> MEM path
        alu(5, 1, 2); alu(6, 5, 5); nop();
        chk("b2b_fwd_a", fwd_a_sel, 2'b10);
        chk("b2b_fwd_b", fwd_b_sel, 2'b10);
        nop(); nop();

        // One independent instruction between -> WB path
        alu(5, 1, 2); alu(9, 3, 4); alu(6, 5, 5); nop();
        chk("gap_fwd_a", fwd_a_sel, 2'b01);
        chk("gap_fwd_b", fwd_b_sel, 2'b01);
        nop(); nop();

        // Same-cycle WB->ID bypass: reader in ID three cycles after producer
        alu(5, 1, 2); nop(); nop(); alu(9, 5, 5);
        chk("byp_a", id_byp_a, 1'b1);
        chk("byp_b", id_byp_b, 1'b1);
        nop(); nop();

        // x5 in both MEM and WB -> MEM wins
        alu(5, 1, 2); alu(5, 3, 4); alu(6, 5, 5); nop();
        chk("memwb_fwd_a", fwd_a_sel, 2'b10);
        nop(); nop();

        // Producer writes x0 -> never forwarded
        alu(0, 1, 2); alu(6, 0, 0); nop();
        chk("x0_fwd_a", fwd_a_sel, 2'b00);
        chk("x0_fwd_b", fwd_b_sel, 2'b00);
        nop(); nop();

        // Load-use: one stall cycle, then WB forwarding
        ld(7, 1); alu(8, 7, 1);
        chk("lu_stall", stall, 1'b1);
        chk("lu_bubble", bubble_id_ex, 1'b1);
        alu(8, 7, 1);
        chk("lu_stall_drop", stall, 1'b0);
        nop();
        chk("lu_fwd_a", fwd_a_sel, 2'b01);
        chk("lu_stall_cnt", stall_cnt, 1);
        nop(); nop();

        // Branch taken during load-use: flush wins over stall
        ld(7, 1); issue(7, 1, 1, 1, 8, 1, 0, 1, 1);
        chk("br_flush", flush_if_id, 1'b1);
        chk("br_bubble", bubble_id_ex, 1'b1);
        chk("br_stall", stall, 1'b0);
        nop();
        chk("br_flush_cnt", flush_cnt, 1);
        chk("br_stall_cnt", stall_cnt, 1);
        nop(); nop();

        // Memory wait during load-use: everything frozen
        ld(7, 1);
        for (int i = 0; i < 3; i++) begin
            issue(7, 1, 1, 1, 8, 1, 0, 0, 0);
            chk("wait_stall", stall, 1'b0);
            chk("wait_stall_cnt", stall_cnt, 1);
        end
        alu(8, 7, 1);
        chk("wait_resume_stall", stall, 1'b1);
        alu(8, 7, 1);
        chk("wait_stall_cnt2", stall_cnt, 2);
        nop(); nop();

        // Drive stall_cnt to saturation and beyond
        for (int i = 0; i < 15; i++) begin
            ld(7, 1); alu(8, 7, 1); alu(8, 7, 1);
        end
        chk("sat_stall_cnt", stall_cnt, CMAX);
        nop(); nop();

        // Asynchronous reset in the middle of a stall
        ld(7, 1); alu(8, 7, 1);
        chk("pre_rst_stall", stall, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_stall", stall, 1'b0);
        chk("arst_bubble", bubble_id_ex, 1'b0);
        chk("arst_stall_cnt", stall_cnt, 0);
        chk("arst_flush_cnt", flush_cnt, 0);
        chk("arst_fwd", {fwd_a_sel, fwd_b_sel}, 4'b0000);
        @(posedge clk);
        #3 rst_n = 1'b1;
        nop();
        chk("post_rst_fwd_a", fwd_a_sel, 2'b00);
        chk("post_rst_fwd_b", fwd_b_sel, 2'b00);
        chk("post_rst_stall_cnt", stall_cnt, 0);
        nop(); nop();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
